// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between debug, EX load/store and instruction fetch.
// Fixed priority dbg > ex > pc, with fetch promoted above EX after MaxWait lost rounds.
module mem_port_arbiter #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32,
    parameter int MaxWait   = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 dbg_req_i,
    input  logic [AddrWidth-1:0] dbg_addr_i,
    input  logic                 dbg_we_i,
    input  logic [DataWidth-1:0] dbg_wdata_i,
    output logic                 dbg_ready_o,
    output logic [DataWidth-1:0] dbg_rdata_o,
    input  logic                 ex_req_i,
    input  logic [AddrWidth-1:0] ex_addr_i,
    input  logic                 ex_we_i,
    input  logic [DataWidth-1:0] ex_wdata_i,
    output logic                 ex_ready_o,
    output logic [DataWidth-1:0] ex_rdata_o,
    input  logic                 pc_req_i,
    input  logic [AddrWidth-1:0] pc_addr_i,
    output logic                 pc_ready_o,
    output logic [DataWidth-1:0] pc_rdata_o,
    input  logic                 pc_flush_i,
    output logic                 s_req_o,
    output logic [AddrWidth-1:0] s_addr_o,
    output logic                 s_we_o,
    output logic [DataWidth-1:0] s_wdata_o,
    input  logic [DataWidth-1:0] s_rdata_i,
    input  logic                 s_ready_i,
    output logic                 hold_o,
    output logic [1:0]           grant_o
);
    localparam int CntWidth = $clog2(MaxWait + 1);
    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_DBG  = 2'd1;
    localparam logic [1:0] GNT_EX   = 2'd2;
    localparam logic [1:0] GNT_PC   = 2'd3;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t                 state_reg;
    logic [1:0]             grant_reg;
    logic                   s_req_reg;
    logic [AddrWidth-1:0]   s_addr_reg;
    logic                   s_we_reg;
    logic [DataWidth-1:0]   s_wdata_reg;
    logic [CntWidth-1:0]    wait_cnt_reg;
    logic                   drop_reg;

    logic                   pc_eligible;
    logic                   pc_promoted;
    logic [1:0]             win_next;
    logic [AddrWidth-1:0]   win_addr;
    logic                   win_we;
    logic [DataWidth-1:0]   win_wdata;
    logic                   done;

    // A flushed fetch must never win, even in the cycle the flush arrives.
    assign pc_eligible = pc_req_i & ~pc_flush_i;
    assign pc_promoted = (wait_cnt_reg >= CntWidth'(MaxWait));

    always_comb begin
        win_next  = GNT_NONE;
        win_addr  = '0;
        win_we    = 1'b0;
        win_wdata = '0;
        if (dbg_req_i) begin
            win_next  = GNT_DBG;
            win_addr  = dbg_addr_i;
            win_we    = dbg_we_i;
            win_wdata = dbg_wdata_i;
        end else if (pc_eligible && (pc_promoted || !ex_req_i)) begin
            win_next  = GNT_PC;
            win_addr  = pc_addr_i;
        end else if (ex_req_i) begin
            win_next  = GNT_EX;
            win_addr  = ex_addr_i;
            win_we    = ex_we_i;
            win_wdata = ex_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= IDLE;
            grant_reg    <= GNT_NONE;
            s_req_reg    <= 1'b0;
            s_addr_reg   <= '0;
            s_we_reg     <= 1'b0;
            s_wdata_reg  <= '0;
            wait_cnt_reg <= '0;
            drop_reg     <= 1'b0;
        end else if (state_reg == IDLE) begin
            if (win_next != GNT_NONE) begin
                state_reg   <= BUSY;
                grant_reg   <= win_next;
                s_req_reg   <= 1'b1;
                s_addr_reg  <= win_addr;
                s_we_reg    <= win_we;
                s_wdata_reg <= win_wdata;
            end
            if (win_next == GNT_PC) begin
                wait_cnt_reg <= '0;
            end else if (pc_eligible && (win_next != GNT_NONE) && !pc_promoted) begin
                wait_cnt_reg <= wait_cnt_reg + CntWidth'(1);
            end
        end else begin
            if (s_ready_i) begin
                state_reg <= IDLE;
                grant_reg <= GNT_NONE;
                s_req_reg <= 1'b0;
                drop_reg  <= 1'b0;
            end else if (pc_flush_i && (grant_reg == GNT_PC)) begin
                drop_reg <= 1'b1;
            end
        end
    end

    // Completion is only meaningful while a transfer is outstanding.
    assign done = s_req_reg & s_ready_i;

    assign dbg_ready_o = done & (grant_reg == GNT_DBG);
    assign ex_ready_o  = done & (grant_reg == GNT_EX);
    assign pc_ready_o  = done & (grant_reg == GNT_PC) & ~drop_reg & ~pc_flush_i;

    assign dbg_rdata_o = {DataWidth{dbg_ready_o}} & s_rdata_i;
    assign ex_rdata_o  = {DataWidth{ex_ready_o}}  & s_rdata_i;
    assign pc_rdata_o  = {DataWidth{pc_ready_o}}  & s_rdata_i;

    assign s_req_o   = s_req_reg;
    assign s_addr_o  = s_addr_reg;
    assign s_we_o    = s_we_reg;
    assign s_wdata_o = s_wdata_reg;
    assign grant_o   = grant_reg;
    assign hold_o    = ex_req_i & ~ex_ready_o;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected transfers are queued when requests are
// driven and checked against the DUT on each ready pulse.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 8;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          dbg_req_i, ex_req_i, pc_req_i;
    logic [AW-1:0] dbg_addr_i, ex_addr_i, pc_addr_i;
    logic          dbg_we_i, ex_we_i;
    logic [DW-1:0] dbg_wdata_i, ex_wdata_i;
    logic          dbg_ready_o, ex_ready_o, pc_ready_o;
    logic [DW-1:0] dbg_rdata_o, ex_rdata_o, pc_rdata_o;
    logic          pc_flush_i;
    logic          s_req_o;
    logic [AW-1:0] s_addr_o;
    logic          s_we_o;
    logic [DW-1:0] s_wdata_o;
    logic [DW-1:0] s_rdata_i;
    logic          s_ready_i;
    logic          hold_o;
    logic [1:0]    grant_o;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter #(.AddrWidth(AW), .DataWidth(DW), .MaxWait(MW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .dbg_req_i(dbg_req_i), .dbg_addr_i(dbg_addr_i), .dbg_we_i(dbg_we_i),
        .dbg_wdata_i(dbg_wdata_i), .dbg_ready_o(dbg_ready_o), .dbg_rdata_o(dbg_rdata_o),
        .ex_req_i(ex_req_i), .ex_addr_i(ex_addr_i), .ex_we_i(ex_we_i),
        .ex_wdata_i(ex_wdata_i), .ex_ready_o(ex_ready_o), .ex_rdata_o(ex_rdata_o),
        .pc_req_i(pc_req_i), .pc_addr_i(pc_addr_i), .pc_ready_o(pc_ready_o),
        .pc_rdata_o(pc_rdata_o), .pc_flush_i(pc_flush_i),
        .s_req_o(s_req_o), .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_wdata_o(s_wdata_o),
        .s_rdata_i(s_rdata_i), .s_ready_i(s_ready_i), .hold_o(hold_o), .grant_o(grant_o)
    );

    typedef struct {
        logic [1:0]    port;
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_done = 0;
    int   done_cnt = 0;
    int   t0 = 0;
    bit   keep_ex = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] p, input logic [AW-1:0] a, input logic w,
                        input logic [DW-1:0] wd, input logic [DW-1:0] rd);
        exp_t e;
        e.port = p; e.addr = a; e.we = w; e.wdata = wd; e.rdata = rd;
        sb.push_back(e);
    endtask

    // One clock; sample 1 ns after the edge, score any completion, retire finished requests.
    task automatic step();
        exp_t          e;
        logic [2:0]    rdy;
        logic [2:0]    exp_rdy;
        logic [DW-1:0] owner_rdata;
        @(posedge clk_i);
        #1;
        cyc++;
        rdy = {pc_ready_o, ex_ready_o, dbg_ready_o};
        if (!dbg_ready_o) chk("dbg_rdata_zero", 64'(dbg_rdata_o), 64'd0);
        if (!ex_ready_o)  chk("ex_rdata_zero", 64'(ex_rdata_o), 64'd0);
        if (!pc_ready_o)  chk("pc_rdata_zero", 64'(pc_rdata_o), 64'd0);
        if (rdy != 3'b000) begin
            done_cnt++;
            last_done = cyc;
            if (sb.size() == 0) begin
                chk("unexpected_ready", 64'(rdy), 64'd0);
            end else begin
                e = sb.pop_front();
                exp_rdy = 3'b001 << (e.port - 2'd1);
                case (e.port)
                    2'd1:    owner_rdata = dbg_rdata_o;
                    2'd2:    owner_rdata = ex_rdata_o;
                    default: owner_rdata = pc_rdata_o;
                endcase
                chk("ready_vec", 64'(rdy), 64'(exp_rdy));
                chk("grant", 64'(grant_o), 64'(e.port));
                chk("s_req", 64'(s_req_o), 64'd1);
                chk("s_addr", 64'(s_addr_o), 64'(e.addr));
                chk("s_we", 64'(s_we_o), 64'(e.we));
                chk("s_wdata", 64'(s_wdata_o), 64'(e.wdata));
                chk("rdata", 64'(owner_rdata), 64'(e.rdata));
            end
            if (dbg_ready_o) dbg_req_i = 1'b0;
            if (ex_ready_o && !keep_ex) ex_req_i = 1'b0;
            if (pc_ready_o) pc_req_i = 1'b0;
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        dbg_req_i = 0; ex_req_i = 0; pc_req_i = 0;
        dbg_addr_i = '0; ex_addr_i = '0; pc_addr_i = '0;
        dbg_we_i = 0; ex_we_i = 0; dbg_wdata_i = '0; ex_wdata_i = '0;
        pc_flush_i = 0; s_rdata_i = '0; s_ready_i = 0;

        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_s_req", 64'(s_req_o), 64'd0);
        chk("rst_grant", 64'(grant_o), 64'd0);
        chk("rst_s_addr", 64'(s_addr_o), 64'd0);
        chk("rst_s_we", 64'(s_we_o), 64'd0);
        chk("rst_s_wdata", 64'(s_wdata_o), 64'd0);
        chk("rst_readies", 64'({dbg_ready_o, ex_ready_o, pc_ready_o}), 64'd0);
        chk("rst_wait_cnt", 64'(dut.wait_cnt_reg), 64'd0);
        rst_ni = 1'b1;
        step();

        // Single EX write with the bus always ready.
        s_ready_i = 1'b1;
        ex_addr_i = 32'h1000_0004; ex_we_i = 1'b1; ex_wdata_i = 32'hDEAD_BEEF;
        ex_req_i = 1'b1;
        push(2'd2, 32'h1000_0004, 1'b1, 32'hDEAD_BEEF, 32'h0);
        #1;
        chk("t1_hold_pending", 64'(hold_o), 64'd1);
        chk("t1_s_req_before", 64'(s_req_o), 64'd0);
        t0 = done_cnt;
        step();
        chk("t1_done_next_cycle", 64'(done_cnt - t0), 64'd1);
        step();
        chk("t1_s_req_idle", 64'(s_req_o), 64'd0);
        chk("t1_addr_stable", 64'(s_addr_o), 64'h1000_0004);

        // All three request together: dbg, ex, pc at two-cycle spacing.
        s_rdata_i = 32'h5A5A_0001;
        dbg_addr_i = 32'h2000_0000; dbg_we_i = 1'b0; dbg_wdata_i = 32'h0000_0011;
        ex_addr_i = 32'h3000_0008;  ex_we_i = 1'b1;  ex_wdata_i = 32'hCAFE_0002;
        pc_addr_i = 32'h0000_0100;
        push(2'd1, 32'h2000_0000, 1'b0, 32'h0000_0011, 32'h5A5A_0001);
        push(2'd2, 32'h3000_0008, 1'b1, 32'hCAFE_0002, 32'h5A5A_0001);
        push(2'd3, 32'h0000_0100, 1'b0, 32'h0, 32'h5A5A_0001);
        dbg_req_i = 1'b1; ex_req_i = 1'b1; pc_req_i = 1'b1;
        step();
        t0 = last_done;
        chk("t2_wait_after_dbg", 64'(dut.wait_cnt_reg), 64'd1);
        step(); step();
        chk("t2_ex_spacing", 64'(last_done - t0), 64'd2);
        chk("t2_wait_after_ex", 64'(dut.wait_cnt_reg), 64'd2);
        step();
        chk("t2_wait_before_pc", 64'(dut.wait_cnt_reg), 64'd2);
        step();
        chk("t2_pc_spacing", 64'(last_done - t0), 64'd4);
        chk("t2_wait_cleared", 64'(dut.wait_cnt_reg), 64'd0);
        chk("t2_sb_drained", 64'(sb.size()), 64'd0);
        step();

        // EX back-to-back starves fetch until the wait counter saturates.
        s_rdata_i = '0;
        ex_addr_i = 32'h4000_0000; ex_we_i = 1'b0; ex_wdata_i = '0;
        pc_addr_i = 32'h0000_0200;
        for (int i = 0; i < MW; i++) push(2'd2, 32'h4000_0000, 1'b0, 32'h0, 32'h0);
        push(2'd3, 32'h0000_0200, 1'b0, 32'h0, 32'h0);
        keep_ex = 1'b1;
        ex_req_i = 1'b1; pc_req_i = 1'b1;
        for (int i = 0; i < 2 * MW; i++) step();
        chk("t3_wait_saturated", 64'(dut.wait_cnt_reg), 64'(MW));
        chk("t3_idle_grant", 64'(grant_o), 64'd0);
        chk("t3_only_pc_left", 64'(sb.size()), 64'd1);
        step();
        chk("t3_wait_cleared", 64'(dut.wait_cnt_reg), 64'd0);
        chk("t3_sb_drained", 64'(sb.size()), 64'd0);
        keep_ex = 1'b0; ex_req_i = 1'b0;
        step();
        chk("t3_idle_after", 64'(s_req_o), 64'd0);

        // Fetch flushed mid-transfer: bus completes, pc_ready suppressed.
        s_ready_i = 1'b0;
        pc_addr_i = 32'h0000_0300; pc_req_i = 1'b1;
        step();
        chk("t4_grant_pc", 64'(grant_o), 64'd3);
        chk("t4_s_req", 64'(s_req_o), 64'd1);
        step();
        pc_flush_i = 1'b1; pc_req_i = 1'b0;
        step();
        pc_flush_i = 1'b0;
        step();
        s_ready_i = 1'b1;
        #1;
        chk("t4_bus_done", 64'(s_req_o), 64'd1);
        chk("t4_pc_ready_dropped", 64'(pc_ready_o), 64'd0);
        step();
        chk("t4_back_idle", 64'(s_req_o), 64'd0);

        // Next fetch is served normally and returns bus read data.
        s_rdata_i = 32'h0000_0013;
        pc_addr_i = 32'h0000_0304; pc_req_i = 1'b1;
        push(2'd3, 32'h0000_0304, 1'b0, 32'h0, 32'h0000_0013);
        t0 = done_cnt;
        step();
        chk("t5_pc_completed", 64'(done_cnt - t0), 64'd1);
        step();

        // Flush in the same cycle as the bus completion.
        s_ready_i = 1'b0;
        pc_addr_i = 32'h0000_0308; pc_req_i = 1'b1;
        step();
        pc_flush_i = 1'b1; s_ready_i = 1'b1; pc_req_i = 1'b0;
        #1;
        chk("t6_same_cycle_dropped", 64'(pc_ready_o), 64'd0);
        step();
        pc_flush_i = 1'b0;
        chk("t6_back_idle", 64'(s_req_o), 64'd0);

        // Asynchronous reset mid-transfer.
        s_ready_i = 1'b0;
        ex_addr_i = 32'h5000_0000; ex_we_i = 1'b1; ex_wdata_i = 32'h1234_5678;
        ex_req_i = 1'b1;
        step();
        chk("t7_busy", 64'(s_req_o), 64'd1);
        chk("t7_grant_ex", 64'(grant_o), 64'd2);
        #3;
        rst_ni = 1'b0;
        #1;
        chk("t7_async_s_req", 64'(s_req_o), 64'd0);
        chk("t7_async_grant", 64'(grant_o), 64'd0);
        ex_req_i = 1'b0; s_ready_i = 1'b1;
        @(posedge clk_i);
        #3;
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t7_idle_s_req", 64'(s_req_o), 64'd0);
            chk("t7_idle_grant", 64'(grant_o), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
